// File: rtl/rf_pkg.sv
// Shared types and constants for the multi-port register file.
// Holds the clear-FSM state encoding and the helper that locates one port inside a flattened bus.
package rf_pkg;

    localparam int unsigned RF_DW  = 32;
    localparam int unsigned RF_AW  = 5;
    localparam int unsigned RF_NRP = 2;

    typedef enum logic {
        RF_IDLE  = 1'b0,
        RF_CLEAR = 1'b1
    } rf_state_t;

    // LSB position of port 'port' in a flattened bus with 'width' bits per port
    function automatic int unsigned port_lsb(input int unsigned port, input int unsigned width);
        return port * width;
    endfunction

endpackage

// File: rtl/rf_read_bypass.sv
// Single read port: selects between the hardwired zero, a same-cycle write and the stored entry.
// With BYPASS=0 it returns the raw entry, apart from the zero register.
module rf_read_bypass
    import rf_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned AW       = RF_AW,
    parameter int unsigned ZERO_REG = 1,
    parameter int unsigned BYPASS   = 1
) (
    input  logic          byp_en,
    input  logic [AW-1:0] addr,
    input  logic [DW-1:0] entry,
    input  logic          we0,
    input  logic [AW-1:0] wa0,
    input  logic [DW-1:0] wd0,
    input  logic          we1,
    input  logic [AW-1:0] wa1,
    input  logic [DW-1:0] wd1,
    output logic [DW-1:0] data_c
);

    logic zero_c;
    logic hit0_c;
    logic hit1_c;

    // Port 1 is checked first because it wins the write collision
    always_comb begin
        zero_c = (ZERO_REG != 0) && (addr == '0);
        hit1_c = (BYPASS != 0) && byp_en && we1 && (wa1 == addr);
        hit0_c = (BYPASS != 0) && byp_en && we0 && (wa0 == addr);
        data_c = entry;
        if (zero_c) begin
            data_c = '0;
        end else if (hit1_c) begin
            data_c = wd1;
        end else if (hit0_c) begin
            data_c = wd0;
        end
    end

endmodule

// File: rtl/rf_multiport.sv
// Register file with NRP bypassed read ports, two prioritised write ports and a
// sequential clear engine that zeroes one entry per cycle.
module rf_multiport
    import rf_pkg::*;
#(
    parameter int unsigned DW       = RF_DW,
    parameter int unsigned AW       = RF_AW,
    parameter int unsigned NRP      = RF_NRP,
    parameter int unsigned ZERO_REG = 1
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we0,
    input  logic [AW-1:0]     wa0,
    input  logic [DW-1:0]     wd0,
    input  logic              we1,
    input  logic [AW-1:0]     wa1,
    input  logic [DW-1:0]     wd1,
    input  logic [NRP*AW-1:0] ra,
    output logic [NRP*DW-1:0] rd,
    input  logic              clr_req,
    output logic              clr_busy,
    output logic              clr_done,
    input  logic [AW-1:0]     dbg_addr,
    output logic [DW-1:0]     dbg_data
);

    localparam int unsigned DEPTH = 1 << AW;

    logic [DW-1:0] mem [DEPTH];
    rf_state_t     state;
    logic [AW-1:0] cnt;

    logic          byp_en_c;
    logic          wr0_c;
    logic          wr1_c;

    // External writes only commit while idle; the zero register never stores
    always_comb begin
        byp_en_c = (state == RF_IDLE);
        wr0_c    = byp_en_c && we0 && !((ZERO_REG != 0) && (wa0 == '0));
        wr1_c    = byp_en_c && we1 && !((ZERO_REG != 0) && (wa1 == '0));
    end

    // Array, clear FSM and status outputs; port 1 is written last so it wins a collision
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state    <= RF_IDLE;
            cnt      <= '0;
            clr_busy <= 1'b0;
            clr_done <= 1'b0;
            for (int i = 0; i < int'(DEPTH); i++) begin
                mem[i] <= '0;
            end
        end else begin
            clr_done <= 1'b0;
            case (state)
                RF_IDLE: begin
                    if (wr0_c) begin
                        mem[wa0] <= wd0;
                    end
                    if (wr1_c) begin
                        mem[wa1] <= wd1;
                    end
                    if (clr_req) begin
                        state    <= RF_CLEAR;
                        cnt      <= '0;
                        clr_busy <= 1'b1;
                    end
                end
                RF_CLEAR: begin
                    mem[cnt] <= '0;
                    if (cnt == AW'(DEPTH - 1)) begin
                        state    <= RF_IDLE;
                        cnt      <= '0;
                        clr_busy <= 1'b0;
                        clr_done <= 1'b1;
                    end else begin
                        cnt <= cnt + AW'(1);
                    end
                end
                default: begin
                    state <= RF_IDLE;
                end
            endcase
        end
    end

    for (genvar k = 0; k < NRP; k++) begin : g_rd
        logic [AW-1:0] addr;
        assign addr = ra[port_lsb(k, AW) +: AW];

        rf_read_bypass #(
            .DW       (DW),
            .AW       (AW),
            .ZERO_REG (ZERO_REG),
            .BYPASS   (1)
        ) u_rd (
            .byp_en (byp_en_c),
            .addr   (addr),
            .entry  (mem[addr]),
            .we0    (we0),
            .wa0    (wa0),
            .wd0    (wd0),
            .we1    (we1),
            .wa1    (wa1),
            .wd1    (wd1),
            .data_c (rd[port_lsb(k, DW) +: DW])
        );
    end

    // Debug port sees raw array contents only
    rf_read_bypass #(
        .DW       (DW),
        .AW       (AW),
        .ZERO_REG (ZERO_REG),
        .BYPASS   (0)
    ) u_dbg (
        .byp_en (1'b0),
        .addr   (dbg_addr),
        .entry  (mem[dbg_addr]),
        .we0    (we0),
        .wa0    (wa0),
        .wd0    (wd0),
        .we1    (we1),
        .wa1    (wa1),
        .wd1    (wd1),
        .data_c (dbg_data)
    );

endmodule

// File: tb/tb_rf_multiport.sv
// Self-checking bench for rf_multiport: directed scenarios plus randomized traffic
// compared against an array-based model of the register file rules.
module tb_rf_multiport;

    localparam int unsigned DW    = 32;
    localparam int unsigned AW    = 5;
    localparam int unsigned NRP   = 2;
    localparam int unsigned DEPTH = 32;

    logic              clk;
    logic              rst;
    logic              we0;
    logic [AW-1:0]     wa0;
    logic [DW-1:0]     wd0;
    logic              we1;
    logic [AW-1:0]     wa1;
    logic [DW-1:0]     wd1;
    logic [NRP*AW-1:0] ra;
    logic [NRP*DW-1:0] rd;
    logic              clr_req;
    logic              clr_busy;
    logic              clr_done;
    logic [AW-1:0]     dbg_addr;
    logic [DW-1:0]     dbg_data;

    int checks = 0;
    int errors = 0;

    // Reference model state
    logic [DW-1:0] m_mem [DEPTH];
    bit            m_clearing;
    int            m_idx;
    bit            m_done;

    rf_multiport #(
        .DW       (DW),
        .AW       (AW),
        .NRP      (NRP),
        .ZERO_REG (1)
    ) dut (
        .clk      (clk),
        .rst      (rst),
        .we0      (we0),
        .wa0      (wa0),
        .wd0      (wd0),
        .we1      (we1),
        .wa1      (wa1),
        .wd1      (wd1),
        .ra       (ra),
        .rd       (rd),
        .clr_req  (clr_req),
        .clr_busy (clr_busy),
        .clr_done (clr_done),
        .dbg_addr (dbg_addr),
        .dbg_data (dbg_data)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic logic [DW-1:0] rd_port(input int k);
        return rd[k*DW +: DW];
    endfunction

    task automatic set_ra(input int k, input logic [AW-1:0] a);
        ra[k*AW +: AW] = a;
    endtask

    // Expected combinational read for the current inputs
    function automatic logic [DW-1:0] exp_rd(input logic [AW-1:0] a);
        if (a == '0) return '0;
        if (!m_clearing && we1 && wa1 == a) return wd1;
        if (!m_clearing && we0 && wa0 == a) return wd0;
        return m_mem[a];
    endfunction

    task automatic model_reset();
        for (int i = 0; i < int'(DEPTH); i++) m_mem[i] = '0;
        m_clearing = 0;
        m_idx      = 0;
        m_done     = 0;
    endtask

    task automatic model_edge();
        if (m_clearing) begin
            m_mem[m_idx] = '0;
            m_idx++;
            m_done = 0;
            if (m_idx == int'(DEPTH)) begin
                m_clearing = 0;
                m_done     = 1;
            end
        end else begin
            m_done = 0;
            if (we0 && wa0 != '0) m_mem[wa0] = wd0;
            if (we1 && wa1 != '0) m_mem[wa1] = wd1;
            if (clr_req) begin
                m_clearing = 1;
                m_idx      = 0;
            end
        end
    endtask

    task automatic step();
        model_edge();
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs();
        we0 = 0; wa0 = '0; wd0 = '0;
        we1 = 0; wa1 = '0; wd1 = '0;
        clr_req = 0; ra = '0; dbg_addr = '0;
    endtask

    task automatic test_reset();
        idle_inputs();
        #3;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL reset_status: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
        end
        @(negedge clk);
        rst = 0;
        model_reset();
        step();
        for (int i = 0; i < 3; i++) begin
            we0 = 1;
            wa0 = (i == 0) ? AW'(5) : (i == 1) ? AW'(9) : AW'(31);
            wd0 = 32'hDEAD_BEEF;
            step();
        end
        we0 = 0;
        set_ra(0, AW'(5));
        set_ra(1, AW'(9));
        dbg_addr = AW'(31);
        #1;
        checks++;
        if (rd_port(0) !== 32'hDEAD_BEEF) begin
            errors++;
            $display("FAIL preload_rd0: got %h expected %h", rd_port(0), 32'hDEAD_BEEF);
        end
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (rd_port(0) !== 32'h0 || rd_port(1) !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL async_rst_reads: got rd0=%h rd1=%h dbg=%h expected all 0",
                     rd_port(0), rd_port(1), dbg_data);
        end
        checks++;
        if (clr_busy !== 1'b0) begin
            errors++;
            $display("FAIL async_rst_busy: got %b expected 0", clr_busy);
        end
        @(negedge clk);
        rst = 0;
        step();
    endtask

    task automatic test_bypass();
        we0 = 1; wa0 = AW'(3); wd0 = 32'h11;
        set_ra(0, AW'(3));
        #1;
        checks++;
        if (rd_port(0) !== 32'h11) begin
            errors++;
            $display("FAIL bypass_rd0: got %h expected %h", rd_port(0), 32'h11);
        end
        step();
        we0 = 0;
        dbg_addr = AW'(3);
        #1;
        checks++;
        if (dbg_data !== 32'h11) begin
            errors++;
            $display("FAIL bypass_dbg: got %h expected %h", dbg_data, 32'h11);
        end
    endtask

    task automatic test_collision();
        we0 = 1; wa0 = AW'(7); wd0 = 32'hAAAA;
        we1 = 1; wa1 = AW'(7); wd1 = 32'h5555;
        set_ra(0, AW'(7));
        #1;
        checks++;
        if (rd_port(0) !== 32'h5555) begin
            errors++;
            $display("FAIL collision_bypass: got %h expected %h", rd_port(0), 32'h5555);
        end
        step();
        we0 = 0; we1 = 0;
        dbg_addr = AW'(7);
        #1;
        checks++;
        if (dbg_data !== 32'h5555 || rd_port(0) !== 32'h5555) begin
            errors++;
            $display("FAIL collision_stored: got dbg=%h rd0=%h expected %h",
                     dbg_data, rd_port(0), 32'h5555);
        end
    endtask

    task automatic test_zero_reg();
        we0 = 1; wa0 = '0; wd0 = 32'hFFFF_FFFF;
        we1 = 1; wa1 = '0; wd1 = 32'h1234_5678;
        set_ra(0, '0);
        set_ra(1, '0);
        #1;
        checks++;
        if (rd_port(0) !== 32'h0 || rd_port(1) !== 32'h0) begin
            errors++;
            $display("FAIL zero_same_cycle: got rd0=%h rd1=%h expected 0", rd_port(0), rd_port(1));
        end
        step();
        we0 = 0; we1 = 0;
        dbg_addr = '0;
        #1;
        checks++;
        if (rd_port(0) !== 32'h0 || dbg_data !== 32'h0) begin
            errors++;
            $display("FAIL zero_after: got rd0=%h dbg=%h expected 0", rd_port(0), dbg_data);
        end
    endtask

    // Runs one sweep from the current idle state and checks its timing
    task automatic run_sweep(input bit poke_entry31);
        int busy_cnt = 0;
        int done_cnt = 0;
        clr_req = 1;
        step();
        clr_req = 0;
        for (int cyc = 0; cyc < 36; cyc++) begin
            if (clr_busy === 1'b1) busy_cnt++;
            if (clr_done === 1'b1) done_cnt++;
            checks++;
            if (clr_busy !== m_clearing || clr_done !== m_done) begin
                errors++;
                $display("FAIL sweep_status cyc%0d: got busy=%b done=%b expected %b %b",
                         cyc, clr_busy, clr_done, m_clearing, m_done);
            end
            if (poke_entry31 && cyc == 5) begin
                we0 = 1; wa0 = AW'(31); wd0 = 32'h1234;
                set_ra(0, AW'(31));
                #1;
                checks++;
                if (rd_port(0) !== 32'd32) begin
                    errors++;
                    $display("FAIL sweep_no_bypass: got %h expected %h", rd_port(0), 32'd32);
                end
            end else begin
                we0 = 0;
                set_ra(1, AW'($urandom_range(0, DEPTH - 1)));
                #1;
                checks++;
                if (rd_port(1) !== exp_rd(ra[AW +: AW])) begin
                    errors++;
                    $display("FAIL sweep_read cyc%0d: got %h expected %h",
                             cyc, rd_port(1), exp_rd(ra[AW +: AW]));
                end
            end
            step();
        end
        we0 = 0;
        checks++;
        if (busy_cnt != int'(DEPTH) || done_cnt != 1) begin
            errors++;
            $display("FAIL sweep_length: got busy=%0d done=%0d expected %0d 1",
                     busy_cnt, done_cnt, DEPTH);
        end
        for (int a = 0; a < int'(DEPTH); a++) begin
            dbg_addr = AW'(a);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL sweep_cleared[%0d]: got %h expected 0", a, dbg_data);
            end
        end
    endtask

    task automatic test_clear();
        for (int a = 0; a < int'(DEPTH); a++) begin
            we0 = 1; wa0 = AW'(a); wd0 = DW'(a + 1);
            step();
        end
        we0 = 0;
        run_sweep(1'b1);
    endtask

    task automatic test_clear_reset();
        int done_seen = 0;
        for (int a = 20; a <= 30; a++) begin
            we1 = 1; wa1 = AW'(a); wd1 = $urandom | 32'h1;
            step();
        end
        we1 = 0;
        clr_req = 1;
        step();
        clr_req = 0;
        repeat (9) step();
        #2;
        rst = 1;
        model_reset();
        #1;
        checks++;
        if (clr_busy !== 1'b0 || clr_done !== 1'b0) begin
            errors++;
            $display("FAIL midsweep_rst: got busy=%b done=%b expected 0 0", clr_busy, clr_done);
        end
        @(negedge clk);
        rst = 0;
        for (int i = 0; i < 40; i++) begin
            step();
            if (clr_done === 1'b1 || clr_busy === 1'b1) done_seen++;
        end
        checks++;
        if (done_seen != 0) begin
            errors++;
            $display("FAIL midsweep_quiet: got %0d active cycles expected 0", done_seen);
        end
        for (int a = 20; a <= 30; a++) begin
            dbg_addr = AW'(a);
            #1;
            checks++;
            if (dbg_data !== 32'h0) begin
                errors++;
                $display("FAIL midsweep_zero[%0d]: got %h expected 0", a, dbg_data);
            end
        end
        run_sweep(1'b0);
    endtask

    task automatic test_random();
        for (int n = 0; n < 400; n++) begin
            we0 = 1'($urandom);
            wa0 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd0 = $urandom;
            we1 = 1'($urandom);
            wa1 = ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom);
            wd1 = $urandom;
            for (int k = 0; k < int'(NRP); k++) begin
                set_ra(k, ($urandom_range(0, 1) == 0) ? AW'($urandom_range(0, 7)) : AW'($urandom));
            end
            dbg_addr = AW'($urandom);
            clr_req  = ($urandom_range(0, 59) == 0);
            #1;
            for (int k = 0; k < int'(NRP); k++) begin
                checks++;
                if (rd_port(k) !== exp_rd(ra[k*AW +: AW])) begin
                    errors++;
                    $display("FAIL rand_rd%0d n%0d: got %h expected %h",
                             k, n, rd_port(k), exp_rd(ra[k*AW +: AW]));
                end
            end
            checks++;
            if (dbg_data !== m_mem[dbg_addr]) begin
                errors++;
                $display("FAIL rand_dbg n%0d: got %h expected %h", n, dbg_data, m_mem[dbg_addr]);
            end
            checks++;
            if (clr_busy !== m_clearing || clr_done !== m_done) begin
                errors++;
                $display("FAIL rand_status n%0d: got busy=%b done=%b expected %b %b",
                         n, clr_busy, clr_done, m_clearing, m_done);
            end
            step();
        end
        idle_inputs();
    endtask

    initial begin
        rst = 1;
        model_reset();
        test_reset();
        test_bypass();
        test_collision();
        test_zero_reg();
        test_clear();
        test_clear_reset();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
